// File: rtl/page_ram_pkg.sv
// Shared definitions for the byte-enable page RAM: lane count helper,
// read-during-write mode encodings and the clear-engine state type.
package page_ram_pkg;

  localparam logic RDW_OLD = 1'b0;
  localparam logic RDW_NEW = 1'b1;

  typedef enum logic {
    READY = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Number of byte lanes covering a word; the top lane may be partial.
  function automatic int lanes(input int data_w, input int sym_w);
    return (data_w + sym_w - 1) / sym_w;
  endfunction

endpackage

// File: rtl/page_ram_core.sv
// Storage array with per-lane write enables and a registered read port.
// Read returns the word stored before a same-edge write (read-first).
module page_ram_core
  import page_ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 40,
  parameter int ADDR_WIDTH   = 16,
  parameter int SYMBOL_WIDTH = 8,
  parameter int LANES        = lanes(DATA_WIDTH, SYMBOL_WIDTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [LANES-1:0]      be,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] wmask;

  for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_wmask
    assign wmask[b] = be[b / SYMBOL_WIDTH];
  end

  // Per-bit write gated by the lane mask so only enabled lanes change.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_WIDTH; b++) begin
        if (wmask[b]) mem[waddr][b] <= wdata[b];
      end
    end
  end

  // Registered read; output holds when no read is issued.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/page_ram_be.sv
// Page RAM top: clear engine FSM, write mux (clear vs user traffic),
// same-address read-during-write bypass and the read valid/output pipeline.
module page_ram_be
  import page_ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 40,
  parameter int ADDR_WIDTH     = 16,
  parameter int SYMBOL_WIDTH   = 8,
  parameter int RD_LATENCY     = 1,
  parameter     RDW_MODE       = "OLD",
  parameter int CLEAR_ON_RESET = 1,
  localparam int LANES         = lanes(DATA_WIDTH, SYMBOL_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [LANES-1:0]      byte_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic                  re,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid,
  output logic                  init_done
);

  localparam logic RDW_SEL = (RDW_MODE == "NEW") ? RDW_NEW : RDW_OLD;

  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("page_ram_be: RD_LATENCY must be 1 or 2");
  end
  if (RDW_MODE != "OLD" && RDW_MODE != "NEW") begin : g_bad_rdw
    $error("page_ram_be: RDW_MODE must be \"OLD\" or \"NEW\"");
  end

  // Lane-wise merge: masked bits come from the write word, others from the stored word.
  function automatic logic [DATA_WIDTH-1:0] lane_merge(
    input logic [DATA_WIDTH-1:0] stored,
    input logic [DATA_WIDTH-1:0] wr_word,
    input logic [DATA_WIDTH-1:0] mask
  );
    return (stored & ~mask) | (wr_word & mask);
  endfunction

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clearing;
  logic                  clr_last;

  logic                  core_we;
  logic [LANES-1:0]      core_be;
  logic [ADDR_WIDTH-1:0] core_waddr;
  logic [DATA_WIDTH-1:0] core_wdata;

  logic                  rd_acc_p0;
  logic                  byp_hit_p0;
  logic [DATA_WIDTH-1:0] be_mask_p0;

  logic                  vld_p1;
  logic                  q_live_p1;
  logic                  byp_hit_p1;
  logic [DATA_WIDTH-1:0] byp_mask_p1;
  logic [DATA_WIDTH-1:0] byp_data_p1;
  logic [DATA_WIDTH-1:0] rdata_p1;
  logic [DATA_WIDTH-1:0] q_p1;

  assign clearing  = (state == CLEAR);
  assign clr_last  = (clr_addr == '1);
  assign init_done = (state == READY);

  // Clear engine state register and address counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clearing ? clr_addr + 1'b1 : '0;
    end
  end

  // Next state: a clear pulse is only honoured from READY.
  always_comb begin
    state_nxt = state;
    case (state)
      READY:   if (clear) state_nxt = CLEAR;
      CLEAR:   if (clr_last) state_nxt = READY;
      default: state_nxt = READY;
    endcase
  end

  // ---- stage p0: write mux, read accept, bypass compare ----
  for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_be_mask
    assign be_mask_p0[b] = byte_en[b / SYMBOL_WIDTH];
  end

  // Clear owns the write port; user traffic only passes in READY.
  always_comb begin
    core_we    = clearing | (init_done & we & (|byte_en));
    core_be    = clearing ? '1 : byte_en;
    core_waddr = clearing ? clr_addr : write_addr;
    core_wdata = clearing ? '0 : data;
    rd_acc_p0  = init_done & re;
    byp_hit_p0 = (RDW_SEL == RDW_NEW) & rd_acc_p0 & we & (read_addr == write_addr);
  end

  page_ram_core #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .SYMBOL_WIDTH(SYMBOL_WIDTH),
    .LANES       (LANES)
  ) u_core (
    .clk  (clk),
    .we   (core_we),
    .be   (core_be),
    .waddr(core_waddr),
    .wdata(core_wdata),
    .re   (rd_acc_p0),
    .raddr(read_addr),
    .rdata(rdata_p1)
  );

  // ---- stage p1: read data out of the array, bypass merge ----
  // Read-valid and bypass-select control, flushed by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      q_live_p1  <= 1'b0;
      byp_hit_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_acc_p0;
      if (rd_acc_p0) begin
        q_live_p1  <= 1'b1;
        byp_hit_p1 <= byp_hit_p0;
      end
    end
  end

  // Write word and lane mask captured alongside each accepted read.
  always_ff @(posedge clk) begin
    if (rd_acc_p0) begin
      byp_mask_p1 <= be_mask_p0;
      byp_data_p1 <= data;
    end
  end

  // q reads as zero until the first read after reset lands.
  assign q_p1 = !q_live_p1 ? '0 :
                byp_hit_p1 ? lane_merge(rdata_p1, byp_data_p1, byp_mask_p1) : rdata_p1;

  // ---- stage p2: optional output register ----
  if (RD_LATENCY == 2) begin : g_lat2
    logic                  vld_p2;
    logic [DATA_WIDTH-1:0] q_p2;

    // Extra output stage; valid delayed to stay aligned with data.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p2 <= 1'b0;
        q_p2   <= '0;
      end else begin
        vld_p2 <= vld_p1;
        if (vld_p1) q_p2 <= q_p1;
      end
    end

    assign q       = q_p2;
    assign q_valid = vld_p2;
  end else begin : g_lat1
    assign q       = q_p1;
    assign q_valid = vld_p1;
  end

endmodule

// File: tb/tb_page_ram_be.sv
// Bench for page_ram_be: two instances share stimulus (latency 1 / OLD and
// latency 2 / NEW); a reference memory feeds per-instance scoreboards.
module tb_page_ram_be;

  localparam int DW = 40;
  localparam int AW = 4;
  localparam int SW = 8;
  localparam int LN = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, we, re, clear;
  logic [DW-1:0] data;
  logic [LN-1:0] byte_en;
  logic [AW-1:0] write_addr, read_addr;
  logic [DW-1:0] q_a, q_b;
  logic          qv_a, qv_b, id_a, id_b;

  page_ram_be #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYMBOL_WIDTH(SW),
    .RD_LATENCY(1), .RDW_MODE("OLD"), .CLEAR_ON_RESET(1)
  ) dut_a (
    .clk(clk), .rst(rst), .data(data), .byte_en(byte_en),
    .write_addr(write_addr), .we(we), .read_addr(read_addr), .re(re),
    .clear(clear), .q(q_a), .q_valid(qv_a), .init_done(id_a)
  );

  page_ram_be #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYMBOL_WIDTH(SW),
    .RD_LATENCY(2), .RDW_MODE("NEW"), .CLEAR_ON_RESET(1)
  ) dut_b (
    .clk(clk), .rst(rst), .data(data), .byte_en(byte_en),
    .write_addr(write_addr), .we(we), .read_addr(read_addr), .re(re),
    .clear(clear), .q(q_b), .q_valid(qv_b), .init_done(id_b)
  );

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  exp_t          sb_a[$];
  exp_t          sb_b[$];
  logic [DW-1:0] model [16];
  logic [DW-1:0] last_a, last_b;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic          rst_q = 1'b1;
  bit            mon_en = 1'b0;
  exp_t          e;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [LN-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < LN; i++) if (be[i]) r[SW*i +: SW] = wd[SW*i +: SW];
    return r;
  endfunction

  always @(posedge clk) begin
    cyc++;
    rst_q = rst;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_q) begin
        check("rst_qv_a", 64'(qv_a), 64'd0);
        check("rst_q_a", 64'(q_a), 64'd0);
        check("rst_qv_b", 64'(qv_b), 64'd0);
        check("rst_q_b", 64'(q_b), 64'd0);
        last_a = '0;
        last_b = '0;
        sb_a.delete();
        sb_b.delete();
      end else begin
        if (qv_a) begin
          check("qv_a_pending", 64'(sb_a.size() != 0), 64'd1);
          if (sb_a.size() != 0) begin
            e = sb_a.pop_front();
            check("qv_a_cycle", 64'(cyc), 64'(e.due));
            check("q_a_data", 64'(q_a), 64'(e.d));
            last_a = e.d;
          end
        end else begin
          check("q_a_hold", 64'(q_a), 64'(last_a));
          if (sb_a.size() != 0) check("qv_a_missing", 64'(sb_a[0].due > cyc), 64'd1);
        end
        if (qv_b) begin
          check("qv_b_pending", 64'(sb_b.size() != 0), 64'd1);
          if (sb_b.size() != 0) begin
            e = sb_b.pop_front();
            check("qv_b_cycle", 64'(cyc), 64'(e.due));
            check("q_b_data", 64'(q_b), 64'(e.d));
            last_b = e.d;
          end
        end else begin
          check("q_b_hold", 64'(q_b), 64'(last_b));
          if (sb_b.size() != 0) check("qv_b_missing", 64'(sb_b[0].due > cyc), 64'd1);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // One cycle of user traffic; expectations are queued when the read is driven.
  task automatic step(input bit w, input int wa, input logic [DW-1:0] wd, input logic [LN-1:0] be,
                      input bit r, input int ra);
    logic [DW-1:0] old;
    we = w; write_addr = AW'(wa); data = wd; byte_en = be;
    re = r; read_addr = AW'(ra);
    if (r) begin
      old = model[ra];
      sb_a.push_back('{old, cyc + 1});
      sb_b.push_back('{(w && wa == ra) ? merge(old, wd, be) : old, cyc + 2});
    end
    if (w) model[wa] = merge(model[wa], wd, be);
    cycle();
    we = 1'b0;
    re = 1'b0;
  endtask

  // Counts edges until each instance reports init_done; optionally re-pulses clear.
  task automatic wait_ready(input int reclear_at, output int na, output int nb);
    na = 0;
    nb = 0;
    for (int n = 1; n <= 60; n++) begin
      cycle();
      clear = (n == reclear_at);
      if (id_a && na == 0) na = n;
      if (id_b && nb == 0) nb = n;
      if (na != 0 && nb != 0) break;
    end
    clear = 1'b0;
  endtask

  task automatic zero_model();
    for (int i = 0; i < 16; i++) model[i] = '0;
  endtask

  int na, nb;

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; clear = 1'b0;
    data = '0; byte_en = '0; write_addr = '0; read_addr = '0;
    last_a = '0; last_b = '0;
    cycle();
    mon_en = 1'b1;
    idle(2);
    check("rst_init_done_a", 64'(id_a), 64'd0);
    check("rst_init_done_b", 64'(id_b), 64'd0);

    // Reset-triggered clear: 16 cycles, then every address reads zero.
    rst = 1'b0;
    wait_ready(0, na, nb);
    check("reset_clear_cycles_a", 64'(na), 64'd16);
    check("reset_clear_cycles_b", 64'(nb), 64'd16);
    zero_model();
    for (int i = 0; i < 16; i++) step(1'b0, 0, '0, '0, 1'b1, i);
    idle(3);
    check("sweep_drained_a", 64'(sb_a.size()), 64'd0);
    check("sweep_drained_b", 64'(sb_b.size()), 64'd0);

    // Byte-enable partial write.
    step(1'b1, 3, 40'hAABBCCDDEE, 5'h1F, 1'b0, 0);
    step(1'b1, 3, 40'h1122334455, 5'b00101, 1'b0, 0);
    step(1'b0, 0, '0, '0, 1'b1, 3);
    idle(3);
    check("byte_en_q_a", 64'(q_a), 64'h00AABB33DD55);
    check("byte_en_q_b", 64'(q_b), 64'h00AABB33DD55);

    // Same-cycle read/write to one address: OLD vs NEW.
    step(1'b1, 7, 40'hFFFFFFFFFF, 5'b00011, 1'b1, 7);
    idle(3);
    check("rdw_old_q_a", 64'(q_a), 64'h0);
    check("rdw_new_q_b", 64'(q_b), 64'h000000FFFF);
    step(1'b0, 0, '0, '0, 1'b1, 7);
    idle(3);
    check("rdw_after_q_a", 64'(q_a), 64'h000000FFFF);

    // Read pattern with a gap: reads on cycles 0, 1, 3.
    step(1'b1, 1, 40'h11, 5'h1F, 1'b0, 0);
    step(1'b1, 2, 40'h22, 5'h1F, 1'b0, 0);
    step(1'b1, 3, 40'h33, 5'h1F, 1'b0, 0);
    step(1'b0, 0, '0, '0, 1'b1, 1);
    step(1'b0, 0, '0, '0, 1'b1, 2);
    step(1'b0, 0, '0, '0, 1'b0, 0);
    step(1'b0, 0, '0, '0, 1'b1, 3);
    idle(3);
    check("lat_last_q_b", 64'(q_b), 64'h33);

    // Write to the read address one cycle after the read: old word returned.
    step(1'b0, 0, '0, '0, 1'b1, 1);
    step(1'b1, 1, 40'hDEADBEEF01, 5'h1F, 1'b0, 0);
    idle(3);
    check("wr_after_rd_q_b", 64'(q_b), 64'h11);

    // we with no lanes enabled changes nothing.
    step(1'b1, 2, 40'hFFFFFFFFFF, 5'b00000, 1'b0, 0);
    step(1'b0, 0, '0, '0, 1'b1, 2);
    idle(3);
    check("noop_write_q_a", 64'(q_a), 64'h22);

    // Clear pulse, with a second pulse mid-clear that must not restart it.
    clear = 1'b1;
    wait_ready(4, na, nb);
    check("clear_cycles_a", 64'(na), 64'd17);
    check("clear_cycles_b", 64'(nb), 64'd17);
    zero_model();
    step(1'b0, 0, '0, '0, 1'b1, 3);
    step(1'b0, 0, '0, '0, 1'b1, 1);
    idle(3);

    // Clear with user traffic in flight, then reset mid-clear.
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    idle(3);
    check("clear_busy_a", 64'(id_a), 64'd0);
    we = 1'b1; re = 1'b1; write_addr = 4'd9; read_addr = 4'd9;
    data = 40'h5A5A5A5A5A; byte_en = 5'h1F;
    idle(2);
    we = 1'b0; re = 1'b0;
    cycle();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    wait_ready(0, na, nb);
    check("rst_mid_clear_cycles_a", 64'(na), 64'd16);
    check("rst_mid_clear_cycles_b", 64'(nb), 64'd16);
    zero_model();
    step(1'b0, 0, '0, '0, 1'b1, 9);
    step(1'b0, 0, '0, '0, 1'b1, 7);
    idle(4);
    check("final_drained_a", 64'(sb_a.size()), 64'd0);
    check("final_drained_b", 64'(sb_b.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/page_ram_be.md
Name: page_ram_be

Overview:
- Simple dual-port page RAM: one write port, one read port, one clock.
- Adds byte-lane write enables, read-valid tracking, selectable read latency (1 or 2), selectable read-during-write result (OLD or NEW), and a sequential clear engine.
- Sits where page payload storage is needed in the packet scheduler. Drop-in for page storage when the scheduler needs partial writes or guaranteed-zero pages.

Parameters:
- DATA_WIDTH, 40, word width in bits.
- ADDR_WIDTH, 16, address width; depth = 2**ADDR_WIDTH.
- SYMBOL_WIDTH, 8, bits per byte lane. LANES = ceil(DATA_WIDTH/SYMBOL_WIDTH); the top lane may be partial.
- RD_LATENCY, 1, cycles from re to q_valid. Legal values are 1 and 2 only; any other value is an elaboration error.
- RDW_MODE, "OLD", result for same-cycle read/write to one address. Legal values are "OLD" and "NEW".
- CLEAR_ON_RESET, 1, 1 = zero the whole RAM after reset before accepting traffic.

Ports:
- clk, in, 1: clock; all logic on the rising edge.
- rst, in, 1: reset, synchronous, active-high.
- data, in, DATA_WIDTH: write data.
- byte_en, in, LANES: per-lane write enable; lane i covers bits [i*SYMBOL_WIDTH +: SYMBOL_WIDTH], clipped at DATA_WIDTH.
- write_addr, in, ADDR_WIDTH: write address.
- we, in, 1: write strobe.
- read_addr, in, ADDR_WIDTH: read address.
- re, in, 1: read strobe.
- clear, in, 1: one-cycle pulse; starts a full-RAM clear.
- q, out, DATA_WIDTH: read data.
- q_valid, out, 1: q holds the result of a read accepted RD_LATENCY cycles earlier.
- init_done, out, 1: high when the RAM accepts traffic (READY state).

Behaviour:
- Reset values: q=0, q_valid=0, read pipeline flushed, clear address counter clr_addr=0.
  - FSM goes to CLEAR and init_done=0 if CLEAR_ON_RESET=1.
  - Otherwise FSM goes to READY and init_done=1.
  - RAM contents are not reset.
- FSM states: READY and CLEAR.
  - READY -> CLEAR on clear=1; clr_addr loads 0.
  - CLEAR: writes all-zero, all lanes, at clr_addr each cycle, then clr_addr increments.
  - CLEAR -> READY on the cycle clr_addr = 2**ADDR_WIDTH-1 is written. init_done rises the next cycle.
  - A full clear takes exactly 2**ADDR_WIDTH cycles.
  - clear asserted while already in CLEAR is ignored; the clear does not restart.
  - rst asserted mid-clear restarts from address 0 (CLEAR_ON_RESET=1) or aborts to READY (CLEAR_ON_RESET=0). Partially cleared contents are left as they are.
- User traffic in CLEAR: we and re are ignored. q_valid stays 0; q holds its last value.
- Write in READY: when we=1, lanes with byte_en[i]=1 are updated; other lanes keep their stored value. we=1 with byte_en=0 is a no-op.
- Read in READY: re=1 samples mem[read_addr].
  - RD_LATENCY=1: q and q_valid update on the next edge.
  - RD_LATENCY=2: data passes through an extra output register; q_valid is delayed to match.
  - re=0: q holds its value and q_valid=0 on the corresponding cycle.
  - Back-to-back reads give one result per cycle; no bubbles.
- Read-during-write, same cycle, re & we & read_addr==write_addr:
  - OLD: returns the pre-write word.
  - NEW: returns a merged word. Enabled lanes take data; disabled lanes take the old stored word. This is built with bypass logic.
- A write to the read address one cycle after the read (RD_LATENCY=2): the read returns the old word. No bypass.
- q_valid counts accepted reads only. The number of q_valid pulses equals the number of re pulses seen in READY.
- Address arithmetic: clr_addr wraps naturally. All addresses are full-range and never out of bounds.

Decomposition:
- Shared package page_ram_pkg:
  - function lanes(DATA_WIDTH, SYMBOL_WIDTH);
  - localparams for RDW_MODE encodings;
  - FSM state enum {READY, CLEAR}.
- Sub-module page_ram_core: pure storage array with per-lane write and registered read, so it infers block RAM.
- Top level page_ram_be holds the FSM, write mux (clear vs user), bypass compare/merge, and valid/output pipeline.

Test Plan:
- Reset clear (ADDR_WIDTH=4, CLEAR_ON_RESET=1):
  - Stimulus: release rst. Once init_done=1, read all 16 addresses.
  - Required: init_done=0 for 16 cycles, then 1. All reads return 0 with q_valid set one cycle after each re.
- Byte-enable write (DATA_WIDTH=40):
  - Stimulus: write 0xAABBCCDDEE, be=5'h1F, addr 3; then write 0x1122334455, be=5'b00101, addr 3; then read addr 3.
  - Required: q=0xAABB33DD55.
- Read-during-write (RDW_MODE="NEW"):
  - Stimulus: addr 7 holds 0x0000000000; in the same cycle, we=1, re=1, addr 7, data 0xFFFFFFFFFF, be=5'b00011.
  - Required: q=0x000000FFFF.
  - The same stimulus with RDW_MODE="OLD" requires q=0x0000000000.
- Latency 2 (RD_LATENCY=2):
  - Stimulus: re pulses on cycles 0, 1, 3 to addrs 1, 2, 3 (preloaded 0x11, 0x22, 0x33).
  - Required: q_valid high on cycles 2, 3, 5 with q = 0x11, 0x22, 0x33.
- Clear mid-traffic and reset mid-clear:
  - Stimulus: pulse clear; 5 cycles in, assert we/re; 8 cycles in, assert rst.
  - Required: we/re have no effect and q_valid stays 0. After rst the clear restarts, and init_done rises exactly 16 cycles after rst deasserts.
